pc_ctrl: RTL and testbench

- Control end of the execute-stage redirect interface: consumes jump_en / jump_addr / hold_en from the execute stage and owns the program counter.
- Generates fetch addresses, redirects on taken branches, squashes wrong-path instructions in the IF/ID register and stalls on instruction-memory back-pressure.
- Sits between the execute stage, the IF/ID pipeline register and instruction ROM.

---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/pc_ctrl_if.sv | 28 ++
 rtl/pc_ctrl.sv | 104 ++++++++++
 tb/tb_pc_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants and types for the program-counter controller.
//   INST_NOP        - instruction the IF/ID register loads when flushed
//   DEF_RESET_ADDR  - default PC after reset
//   pc_state_e      - controller FSM states (IDLE, RUN, FLUSH)
//   word_align()    - clears the byte-offset bits of an address
package pc_ctrl_pkg;

    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_RUN   = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: execute-stage redirect inputs and fetch-side outputs of the
// program-counter controller.
//   master : execute stage / instruction memory side (drives jump/hold/ready)
//   slave  : pc_ctrl (drives pc_o, fetch_req, flush_o, status and counters)
interface pc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              jump_en;
    logic [31:0]       jump_addr;
    logic              hold_en;
    logic              fetch_ready;
    logic [31:0]       pc_o;
    logic              fetch_req;
    logic              flush_o;
    logic              misalign_err;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output jump_en, jump_addr, hold_en, fetch_ready,
        input  pc_o, fetch_req, flush_o, misalign_err, branch_cnt, taken_cnt
    );

    modport slave (
        input  jump_en, jump_addr, hold_en, fetch_ready,
        output pc_o, fetch_req, flush_o, misalign_err, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: owns the program counter. Increments on fetch_ready, holds on
// back-pressure, redirects on a taken jump from the execute stage and
// squashes wrong-path IF/ID contents for FLUSH_CYCLES cycles.
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - pc_ctrl_if slave: jump_en/jump_addr/hold_en/fetch_ready in,
//          pc_o/fetch_req/flush_o/misalign_err/branch_cnt/taken_cnt out
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR   = DEF_RESET_ADDR,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic      clk,
    input  logic      rst,
    pc_ctrl_if.slave  bus
);

    // The jump cycle itself is the first flush cycle, so FLUSH holds for
    // the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    pc_state_e         state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  br_q, br_d;
    logic [CNT_W-1:0]  tk_q, tk_d;
    logic              flush;
    logic              fetch_req;
    logic              jump_ok;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fcnt_d    = fcnt_q;
        mis_d     = mis_q;
        br_d      = br_q;
        tk_d      = tk_q;
        flush     = 1'b0;
        fetch_req = 1'b0;
        jump_ok   = bus.jump_en && (state_q != PC_IDLE);

        case (state_q)
            PC_IDLE: state_d = PC_RUN;
            PC_RUN, PC_FLUSH: begin
                fetch_req = 1'b1;
                flush     = (state_q == PC_FLUSH);
                if (jump_ok) begin
                    // Redirect beats both increment and stall; newest target wins.
                    flush   = 1'b1;
                    pc_d    = word_align(bus.jump_addr);
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_CYCLES > 1) ? PC_FLUSH : PC_RUN;
                end else begin
                    if (bus.fetch_ready)
                        pc_d = pc_q + 32'd4;
                    if (state_q == PC_FLUSH) begin
                        fcnt_d = fcnt_q - 3'd1;
                        if (fcnt_q <= 3'd1)
                            state_d = PC_RUN;
                    end
                end
            end
            default: state_d = PC_IDLE;
        endcase

        if (jump_ok && (bus.jump_addr[1:0] != 2'b00))
            mis_d = 1'b1;

        // Statistics counters saturate at all-ones.
        if (bus.hold_en && !(&br_q))
            br_d = br_q + CNT_W'(1);
        if (bus.jump_en && !(&tk_q))
            tk_d = tk_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_IDLE;
            pc_q    <= RESET_ADDR;
            fcnt_q  <= 3'd0;
            mis_q   <= 1'b0;
            br_q    <= '0;
            tk_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            mis_q   <= mis_d;
            br_q    <= br_d;
            tk_q    <= tk_d;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.fetch_req    = fetch_req;
    assign bus.flush_o      = flush;
    assign bus.misalign_err = mis_q;
    assign bus.branch_cnt   = br_q;
    assign bus.taken_cnt    = tk_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: drives two pc_ctrl instances with identical stimulus
// (FLUSH_CYCLES=1/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=2) and compares every
// output each cycle against a cycle-level reference model of the PC,
// remaining-flush count and statistics.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_ctrl_if #(.CNT_W(16)) bus_a ();
    pc_ctrl_if #(.CNT_W(2))  bus_b ();

    pc_ctrl #(.RESET_ADDR(32'h0), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    pc_ctrl #(.RESET_ADDR(32'h0), .FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    int          fc   [2] = '{1, 3};
    int          cmax [2] = '{65535, 3};
    logic [31:0] m_pc [2];
    int          m_fl [2];
    bit          m_run;
    int          m_br, m_tk;
    bit          m_mis;

    logic        cur_je, cur_he, cur_fr;
    logic [31:0] cur_ja;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 32'h0;
            m_fl[d] = 0;
        end
        m_run = 0; m_br = 0; m_tk = 0; m_mis = 0;
    endtask

    task automatic drive(input logic je, input logic [31:0] ja, input logic he, input logic fr);
        cur_je = je; cur_ja = ja; cur_he = he; cur_fr = fr;
        bus_a.jump_en = je; bus_a.jump_addr = ja; bus_a.hold_en = he; bus_a.fetch_ready = fr;
        bus_b.jump_en = je; bus_b.jump_addr = ja; bus_b.hold_en = he; bus_b.fetch_ready = fr;
    endtask

    task automatic check_all();
        logic [31:0] pc, bc, tc;
        logic        fq, fl, mi;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                pc = bus_a.pc_o; fq = bus_a.fetch_req; fl = bus_a.flush_o; mi = bus_a.misalign_err;
                bc = 32'(bus_a.branch_cnt); tc = 32'(bus_a.taken_cnt);
            end else begin
                pc = bus_b.pc_o; fq = bus_b.fetch_req; fl = bus_b.flush_o; mi = bus_b.misalign_err;
                bc = 32'(bus_b.branch_cnt); tc = 32'(bus_b.taken_cnt);
            end
            check($sformatf("pc_o[%0d]", d), pc, m_pc[d]);
            check($sformatf("fetch_req[%0d]", d), 32'(fq), 32'(m_run));
            check($sformatf("flush_o[%0d]", d), 32'(fl), 32'(m_run && (cur_je || m_fl[d] > 0)));
            check($sformatf("misalign[%0d]", d), 32'(mi), 32'(m_mis));
            check($sformatf("branch_cnt[%0d]", d), bc, 32'((m_br < cmax[d]) ? m_br : cmax[d]));
            check($sformatf("taken_cnt[%0d]", d), tc, 32'((m_tk < cmax[d]) ? m_tk : cmax[d]));
        end
    endtask

    // One clock: apply inputs, check at the falling edge, advance model at
    // the rising edge.
    task automatic step(input logic je, input logic [31:0] ja, input logic he, input logic fr);
        drive(je, ja, he, fr);
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (he) m_br++;
        if (je) m_tk++;
        if (m_run) begin
            if (je && ja[1:0] != 2'b00) m_mis = 1;
            for (int d = 0; d < 2; d++) begin
                if (je) begin
                    m_pc[d] = ja & 32'hFFFF_FFFC;
                    m_fl[d] = fc[d] - 1;
                end else begin
                    if (fr) m_pc[d] = m_pc[d] + 32'd4;
                    if (m_fl[d] > 0) m_fl[d]--;
                end
            end
        end
        m_run = 1;
        #1;
    endtask

    // Asynchronous reset between edges, then release after one clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_pc_b", bus_b.pc_o, 32'h0);
        check("rst_flush_b", 32'(bus_b.flush_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // IDLE, then 0,4,8,12 in RUN
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("run_pc16", bus_a.pc_o, 32'h10);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        check("jump_pc40", bus_a.pc_o, 32'h40);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("jump_pc44", bus_a.pc_o, 32'h44);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Stall then jump during the stall
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        check("stall_jump_pc", bus_a.pc_o, 32'h80);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Re-jump inside the FLUSH window of the 3-cycle instance
        step(1'b1, 32'h100, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        check("rejump_pc", bus_b.pc_o, 32'h200);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

        // Not-taken branches
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("branch_cnt5", 32'(bus_a.branch_cnt), 32'd5);

        // Misaligned target
        step(1'b1, 32'h102, 1'b0, 1'b1);
        check("mis_pc", bus_a.pc_o, 32'h100);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("mis_sticky", 32'(bus_a.misalign_err), 32'd1);
        check("taken_sat", 32'(bus_b.taken_cnt), 32'd3);

        // 32-bit wrap
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("pc_wrap", bus_a.pc_o, 32'h0);

        // Reset while the 3-cycle instance is flushing
        step(1'b1, 32'h300, 1'b0, 1'b1);
        drive(1'b1, 32'h500, 1'b1, 1'b0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        je, he, fr;
            logic [31:0] ja;
            je = ($urandom_range(0, 7) == 0);
            ja = $urandom;
            he = ($urandom_range(0, 2) == 0);
            fr = ($urandom_range(0, 3) != 0);
            step(je, ja, he, fr);
            if (i == 200) begin
                drive(1'b0, 32'h0, 1'b0, 1'b1);
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
